// File: rtl/barrier_scroller_if.sv
// Bundles the frame-update controls and the barrier state outputs of barrier_scroller.
// Use the slave modport on the scroller and the master modport on the block driving it.
interface barrier_scroller_if #(
   parameter int NUM_SLOTS = 4,
   parameter int X_W       = 10,
   parameter int SPEED_W   = 4
);
   logic                     frame_tick;
   logic                     clear;
   logic [SPEED_W-1:0]       barrier_speed;
   logic [NUM_SLOTS*X_W-1:0] barrier_x;
   logic [NUM_SLOTS*2-1:0]   barrier_h;
   logic [NUM_SLOTS-1:0]     barrier_valid;
   logic [7:0]               pass_cnt;
   logic                     pass_pulse;
   logic                     busy;
   logic                     update_done;
   logic                     overrun;

   modport master (
      output frame_tick, clear, barrier_speed,
      input  barrier_x, barrier_h, barrier_valid, pass_cnt, pass_pulse,
             busy, update_done, overrun
   );

   modport slave (
      input  frame_tick, clear, barrier_speed,
      output barrier_x, barrier_h, barrier_valid, pass_cnt, pass_pulse,
             busy, update_done, overrun
   );
endinterface

// File: rtl/barrier_scroller.sv
// Once per frame, scrolls the barrier slots left, retires and counts off-screen ones, and spawns new ones.
// Define RANDOM_SPAWN_EN to randomise the spawn gap and height from the LFSR; otherwise spacing is fixed.
module barrier_scroller #(
   parameter int         NUM_SLOTS     = 4,
   parameter int         X_W           = 10,
   parameter int         SPEED_W       = 4,
   parameter int         SCREEN_W      = 640,
   parameter int         SPAWN_GAP_MIN = 160,
   parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
   input  logic                clk,
   input  logic                rst_n,
   barrier_scroller_if.slave   io_bus
);
   localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int D_W   = 10;

   typedef enum logic [1:0] {IDLE, MOVE, SPAWN, DONE} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 w_busy;
   logic                 w_update_done;

   logic [SPEED_W-1:0]   r_spd;
   logic [IDX_W-1:0]     r_idx;
   logic [X_W-1:0]       r_x [NUM_SLOTS];
   logic [1:0]           r_h [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] r_valid;
   logic [7:0]           r_pass_cnt;
   logic                 r_pass_pulse;
   logic                 r_overrun;
   logic [D_W-1:0]       r_spawn_dist;
   logic [7:0]           r_lfsr;

   logic [X_W-1:0]       w_spd_ext;
   logic [D_W:0]         w_dist_sum;
   logic [D_W-1:0]       w_dist_new;
   logic [D_W:0]         w_gap_thr;
   logic [5:0]           w_gap_rand;
   logic [1:0]           w_h_rand;
   logic                 w_free_any;
   logic [IDX_W-1:0]     w_free_idx;
   logic                 w_spawn_ok;
   logic [NUM_SLOTS*X_W-1:0] w_x_pack;
   logic [NUM_SLOTS*2-1:0]   w_h_pack;

`ifdef RANDOM_SPAWN_EN
   assign w_gap_rand = r_lfsr[5:0];
   assign w_h_rand   = r_lfsr[7:6];
`else
   logic w_lfsr_unused;
   assign w_gap_rand    = 6'd0;
   assign w_h_rand      = 2'd1;
   assign w_lfsr_unused = ^r_lfsr;
`endif

   assign w_spd_ext  = X_W'(r_spd);
   assign w_dist_sum = {1'b0, r_spawn_dist} + (D_W+1)'(r_spd);
   // The sum can never exceed 2*1023, so the carry bit alone flags saturation.
   assign w_dist_new = w_dist_sum[D_W] ? {D_W{1'b1}} : w_dist_sum[D_W-1:0];
   assign w_gap_thr  = (D_W+1)'(SPAWN_GAP_MIN) + (D_W+1)'(w_gap_rand);
   assign w_free_any = ~&r_valid;
   assign w_spawn_ok = ({1'b0, w_dist_new} >= w_gap_thr) && w_free_any;

   always_comb begin
      w_free_idx = '0;
      for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
         if (!r_valid[k]) w_free_idx = IDX_W'(k);
      end
   end

   always_comb begin
      w_x_pack = '0;
      w_h_pack = '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
         w_x_pack[k*X_W +: X_W] = r_x[k];
         w_h_pack[k*2 +: 2]     = r_h[k];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else if (io_bus.clear) r_state <= IDLE;
      else r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_busy        = 1'b1;
      w_update_done = 1'b0;
      case (r_state)
         IDLE: begin
            w_busy = 1'b0;
            if (io_bus.frame_tick) w_state_nxt = MOVE;
         end
         MOVE: begin
            if (r_idx == IDX_W'(NUM_SLOTS - 1)) w_state_nxt = SPAWN;
         end
         SPAWN: w_state_nxt = DONE;
         DONE: begin
            w_busy        = 1'b0;
            w_update_done = 1'b1;
            w_state_nxt   = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_spd        <= '0;
         r_idx        <= '0;
         r_valid      <= '0;
         r_pass_cnt   <= '0;
         r_pass_pulse <= 1'b0;
         r_overrun    <= 1'b0;
         r_spawn_dist <= '0;
         r_lfsr       <= LFSR_SEED;
         for (int k = 0; k < NUM_SLOTS; k++) begin
            r_x[k] <= '0;
            r_h[k] <= '0;
         end
      end else begin
         // Taps 8,6,5,4; the LFSR keeps running through clear so restarts do not replay the same pattern.
         r_lfsr       <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
         r_pass_pulse <= 1'b0;
         if (io_bus.clear) begin
            r_valid      <= '0;
            r_pass_cnt   <= '0;
            r_overrun    <= 1'b0;
            r_spawn_dist <= '0;
            r_idx        <= '0;
            for (int k = 0; k < NUM_SLOTS; k++) begin
               r_x[k] <= '0;
               r_h[k] <= '0;
            end
         end else begin
            if (io_bus.frame_tick && (r_state != IDLE)) r_overrun <= 1'b1;
            case (r_state)
               IDLE: begin
                  if (io_bus.frame_tick) begin
                     r_spd <= io_bus.barrier_speed;
                     r_idx <= '0;
                  end
               end
               MOVE: begin
                  if (r_valid[r_idx] && (r_x[r_idx] < w_spd_ext)) begin
                     r_valid[r_idx] <= 1'b0;
                     r_pass_pulse   <= 1'b1;
                     if (r_pass_cnt != 8'hFF) r_pass_cnt <= r_pass_cnt + 8'd1;
                  end else if (r_valid[r_idx]) begin
                     r_x[r_idx] <= r_x[r_idx] - w_spd_ext;
                  end
                  r_idx <= r_idx + IDX_W'(1);
               end
               SPAWN: begin
                  if (w_spawn_ok) begin
                     r_x[w_free_idx]     <= X_W'(SCREEN_W - 1);
                     r_h[w_free_idx]     <= w_h_rand;
                     r_valid[w_free_idx] <= 1'b1;
                     r_spawn_dist        <= '0;
                  end else begin
                     r_spawn_dist <= w_dist_new;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign io_bus.barrier_x     = w_x_pack;
   assign io_bus.barrier_h     = w_h_pack;
   assign io_bus.barrier_valid = r_valid;
   assign io_bus.pass_cnt      = r_pass_cnt;
   assign io_bus.pass_pulse    = r_pass_pulse;
   assign io_bus.busy          = w_busy;
   assign io_bus.update_done   = w_update_done;
   assign io_bus.overrun       = r_overrun;
endmodule

// File: tb/tb_barrier_scroller.sv
// Directed bench for barrier_scroller in its default build (fixed 160-pixel gap, height code 1).
module tb_barrier_scroller;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   barrier_scroller_if bus_if ();
   barrier_scroller dut (.clk(clk), .rst_n(rst_n), .io_bus(bus_if));

   int n_checks = 0;
   int n_pass = 0;
   int lat, pulses, busy1;
   int lat_bad = 0;
   int tot_pulses = 0;
   int n, extra;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   function automatic logic [9:0] x_of(input int s);
      return bus_if.barrier_x[s*10 +: 10];
   endfunction

   function automatic logic [1:0] h_of(input int s);
      return bus_if.barrier_h[s*2 +: 2];
   endfunction

   // Pulses frame_tick for one cycle and waits (bounded) for update_done, then one more cycle.
   task automatic do_frame(input logic [3:0] spd);
      bus_if.barrier_speed = spd;
      bus_if.frame_tick    = 1'b1;
      lat = 0;
      pulses = 0;
      busy1 = 0;
      do begin
         @(negedge clk);
         bus_if.frame_tick = 1'b0;
         lat++;
         if (lat == 1) busy1 = bus_if.busy;
         if (bus_if.pass_pulse) pulses++;
      end while (!bus_if.update_done && lat < 20);
      if (lat != 6) lat_bad++;
      tot_pulses += pulses;
      @(negedge clk);
   endtask

   task automatic run_frames(input int cnt, input logic [3:0] spd);
      for (int f = 0; f < cnt; f++) do_frame(spd);
   endtask

   task automatic pulse_clear();
      bus_if.clear = 1'b1;
      @(negedge clk);
      bus_if.clear = 1'b0;
   endtask

   initial begin
      bus_if.frame_tick    = 1'b0;
      bus_if.clear         = 1'b0;
      bus_if.barrier_speed = 4'd0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_valid", bus_if.barrier_valid, 0);
      check("rst_x", bus_if.barrier_x, 0);
      check("rst_h", bus_if.barrier_h, 0);
      check("rst_pass_cnt", bus_if.pass_cnt, 0);
      check("rst_pulse", bus_if.pass_pulse, 0);
      check("rst_busy", bus_if.busy, 0);
      check("rst_done", bus_if.update_done, 0);
      check("rst_overrun", bus_if.overrun, 0);
      rst_n = 1'b1;
      @(negedge clk);

      do_frame(4'd0);
      check("busy_in_move", busy1, 1);
      check("latency", lat, 6);
      run_frames(2, 4'd0);
      check("spd0_valid", bus_if.barrier_valid, 0);
      check("spd0_busy_after", bus_if.busy, 0);

      // Speed 4: spawn_dist reaches 160 on tick 40.
      run_frames(39, 4'd4);
      check("t39_valid", bus_if.barrier_valid, 0);
      do_frame(4'd4);
      check("t40_valid", bus_if.barrier_valid, 4'b0001);
      check("t40_x0", x_of(0), 639);
      check("t40_h0", h_of(0), 1);
      do_frame(4'd4);
      check("t41_x0", x_of(0), 635);
      run_frames(38, 4'd4);
      check("t79_valid", bus_if.barrier_valid, 4'b0001);
      do_frame(4'd4);
      check("t80_valid", bus_if.barrier_valid, 4'b0011);
      check("t80_x1", x_of(1), 639);
      check("t80_x0", x_of(0), 479);
      run_frames(80, 4'd4);
      check("t160_valid", bus_if.barrier_valid, 4'b1111);
      check("t160_x3", x_of(3), 639);
      check("t160_x0", x_of(0), 159);
      run_frames(39, 4'd4);
      check("t199_x0", x_of(0), 3);
      check("t199_pass_cnt", bus_if.pass_cnt, 0);
      // Slot 0 retires (3 < 4) and is refilled by the spawn of the same frame.
      do_frame(4'd4);
      check("t200_pulses", pulses, 1);
      check("t200_pass_cnt", bus_if.pass_cnt, 1);
      check("t200_valid", bus_if.barrier_valid, 4'b1111);
      check("t200_x0", x_of(0), 639);
      check("t200_x1", x_of(1), 159);
      check("t200_x3", x_of(3), 479);
      check("latency_all", lat_bad, 0);

      // Second tick at cycle 3 is ignored; speed change after cycle 0 has no effect.
      bus_if.barrier_speed = 4'd15;
      bus_if.frame_tick    = 1'b1;
      @(negedge clk);
      bus_if.frame_tick    = 1'b0;
      bus_if.barrier_speed = 4'd0;
      @(negedge clk);
      @(negedge clk);
      bus_if.frame_tick = 1'b1;
      @(negedge clk);
      bus_if.frame_tick = 1'b0;
      n = 0;
      while (!bus_if.update_done && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ovr_done_seen", (n < 20), 1);
      check("ovr_flag", bus_if.overrun, 1);
      extra = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus_if.update_done) extra++;
      end
      check("ovr_no_second_update", extra, 0);
      check("ovr_x1_latched_speed", x_of(1), 144);
      check("ovr_x0_latched_speed", x_of(0), 624);
      do_frame(4'd0);
      check("ovr_sticky", bus_if.overrun, 1);
      pulse_clear();
      check("clr_overrun", bus_if.overrun, 0);
      check("clr_valid", bus_if.barrier_valid, 0);
      check("clr_pass_cnt", bus_if.pass_cnt, 0);

      // x == speed: moves to 0 and stays valid, retires on the next nonzero-speed frame.
      run_frames(40, 4'd4);
      check("eq_spawn_valid0", bus_if.barrier_valid[0], 1);
      run_frames(42, 4'd15);
      check("eq_x0_9", x_of(0), 9);
      check("eq_pass_cnt0", bus_if.pass_cnt, 0);
      do_frame(4'd9);
      check("eq_x0_zero", x_of(0), 0);
      check("eq_valid0_kept", bus_if.barrier_valid[0], 1);
      do_frame(4'd0);
      check("eq_valid0_spd0", bus_if.barrier_valid[0], 1);
      do_frame(4'd1);
      check("eq_retired", bus_if.barrier_valid[0], 0);
      check("eq_pulses", pulses, 1);
      check("eq_pass_cnt1", bus_if.pass_cnt, 1);

      // Clear during MOVE aborts the frame.
      bus_if.barrier_speed = 4'd4;
      bus_if.frame_tick    = 1'b1;
      @(negedge clk);
      bus_if.frame_tick = 1'b0;
      @(negedge clk);
      pulse_clear();
      check("mid_clr_valid", bus_if.barrier_valid, 0);
      check("mid_clr_pass_cnt", bus_if.pass_cnt, 0);
      check("mid_clr_busy", bus_if.busy, 0);
      extra = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bus_if.update_done) extra++;
      end
      check("mid_clr_no_done", extra, 0);

      // Speed 15 from empty: spawns every 11 frames, each retires 43 frames after spawning.
      tot_pulses = 0;
      lat_bad = 0;
      run_frames(3000, 4'd15);
      check("sat_pass_cnt", bus_if.pass_cnt, 255);
      check("sat_total_retired", tot_pulses, 268);
      check("sat_latency", lat_bad, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
